// File: rtl/bj_pkg.sv
// Shared constants, state encodings and the rank-to-value helper
// used by the blackjack card shoe.
package bj_pkg;

  localparam logic [5:0]  DECK_SIZE = 6'd52;
  localparam logic [3:0]  RANK_ACE  = 4'd1;
  localparam logic [3:0]  RANK_KING = 4'd13;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PICK,
    ST_PROBE,
    ST_DELIVER
  } shoe_state_t;

  typedef enum logic [1:0] {
    SRC_RANDOM,
    SRC_SCRIPT,
    SRC_ERROR
  } draw_src_t;

  // Ace counts high; picture cards count ten.
  function automatic logic [5:0] card_value_of(input logic [3:0] rank);
    logic [5:0] value;
    if (rank == RANK_ACE)
      value = 6'd11;
    else if (rank > 4'd10)
      value = 6'd10;
    else
      value = {2'b00, rank};
    return value;
  endfunction

endpackage

// File: rtl/card_script_fifo.sv
// Small synchronous FIFO holding forced card ranks; dout shows the
// head entry so a pop can capture it in the same cycle.
module card_script_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [3:0] din,
  input  logic       rd,
  output logic [3:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/card_shoe.sv
// Single-deck card source: serves one card per draw request, either from
// the script FIFO or at random from the undealt cards without repeats.
module card_shoe
  import bj_pkg::*;
#(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          SCRIPT_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shuffle,
  input  logic       draw_req,
  input  logic       script_wr,
  input  logic [3:0] script_rank,
  output logic       draw_ack,
  output logic       draw_err,
  output logic [5:0] card_value,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       script_full,
  output logic       busy
);

  shoe_state_t        state;
  shoe_state_t        next_state;
  draw_src_t          src;
  logic [15:0]        lfsr;
  logic [51:0]        mask;
  logic [5:0]         idx;
  logic [5:0]         pick_idx;
  logic [5:0]         probe_idx;
  logic [5:0]         lfsr_low;
  logic [3:0]         rand_rank;
  logic [1:0]         rand_suit;
  logic               req_q;
  logic               req_edge;
  logic               fifo_rd;
  logic               fifo_empty;
  logic [3:0]         fifo_dout;
  logic [3:0]         script_din;
  logic [3:0]         pend_rank;

  assign req_edge   = draw_req && !req_q;
  assign deck_empty = (cards_left == 6'd0);
  assign busy       = (state != ST_IDLE);
  assign script_din = (script_rank == 4'd0 || script_rank > RANK_KING) ? 4'd10 : script_rank;
  assign lfsr_low   = lfsr[5:0];
  assign pick_idx   = (lfsr_low < DECK_SIZE) ? lfsr_low : lfsr_low - 6'd12;
  assign probe_idx  = (idx == DECK_SIZE - 6'd1) ? 6'd0 : idx + 6'd1;
  assign rand_rank  = 4'(idx % 6'd13) + 4'd1;
  assign rand_suit  = 2'(idx / 6'd13);

  card_script_fifo #(.DEPTH(SCRIPT_DEPTH)) u_script_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (script_wr),
    .din   (script_din),
    .rd    (fifo_rd),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (script_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr  <= SEED;
      req_q <= 1'b0;
      state <= ST_IDLE;
    end else begin
      lfsr  <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
      req_q <= draw_req;
      state <= next_state;
    end
  end

  // Shuffle overrides every transition, including a same-cycle request.
  always_comb begin
    next_state = state;
    fifo_rd    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_edge && !shuffle) begin
          if (!fifo_empty) begin
            fifo_rd    = 1'b1;
            next_state = ST_DELIVER;
          end else if (deck_empty) begin
            next_state = ST_DELIVER;
          end else begin
            next_state = ST_PICK;
          end
        end
      end
      ST_PICK:    next_state = mask[pick_idx] ? ST_PROBE : ST_DELIVER;
      ST_PROBE:   next_state = mask[probe_idx] ? ST_PROBE : ST_DELIVER;
      ST_DELIVER: next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
    if (shuffle)
      next_state = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask       <= '0;
      cards_left <= DECK_SIZE;
      idx        <= 6'd0;
      src        <= SRC_RANDOM;
      pend_rank  <= 4'd0;
      draw_ack   <= 1'b0;
      draw_err   <= 1'b0;
      card_value <= 6'd0;
      card_rank  <= 4'd0;
      card_suit  <= 2'd0;
    end else begin
      draw_ack <= 1'b0;
      draw_err <= 1'b0;
      if (shuffle) begin
        mask       <= '0;
        cards_left <= DECK_SIZE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req_edge) begin
              if (!fifo_empty) begin
                src       <= SRC_SCRIPT;
                pend_rank <= fifo_dout;
              end else if (deck_empty) begin
                src <= SRC_ERROR;
              end else begin
                src <= SRC_RANDOM;
              end
            end
          end
          ST_PICK:  idx <= pick_idx;
          ST_PROBE: idx <= probe_idx;
          ST_DELIVER: begin
            draw_ack <= 1'b1;
            case (src)
              SRC_SCRIPT: begin
                card_rank  <= pend_rank;
                card_suit  <= 2'd0;
                card_value <= card_value_of(pend_rank);
              end
              SRC_ERROR: begin
                draw_err   <= 1'b1;
                card_value <= 6'd0;
              end
              default: begin
                mask[idx]  <= 1'b1;
                cards_left <= cards_left - 6'd1;
                card_rank  <= rand_rank;
                card_suit  <= rand_suit;
                card_value <= card_value_of(rand_rank);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: scripted hands, a full random deal,
// empty-deck error, shuffle abort, FIFO overflow and mid-draw reset.
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       reset;
  logic       shuffle;
  logic       draw_req;
  logic       script_wr;
  logic [3:0] script_rank;
  logic       draw_ack;
  logic       draw_err;
  logic [5:0] card_value;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       script_full;
  logic       busy;

  typedef enum int {KIND_SCRIPT, KIND_RANDOM, KIND_ERROR} kind_t;
  typedef struct {
    kind_t kind;
    int    rank;
    int    value;
  } sb_item_t;

  sb_item_t sb_queue[$];
  int       compared   = 0;
  int       mismatched = 0;
  int       ack_count  = 0;
  int       model_left = 52;
  int       ack_before;
  bit       seen[52];

  card_shoe #(.SEED(16'hACE1), .SCRIPT_DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .shuffle     (shuffle),
    .draw_req    (draw_req),
    .script_wr   (script_wr),
    .script_rank (script_rank),
    .draw_ack    (draw_ack),
    .draw_err    (draw_err),
    .card_value  (card_value),
    .card_rank   (card_rank),
    .card_suit   (card_suit),
    .cards_left  (cards_left),
    .deck_empty  (deck_empty),
    .script_full (script_full),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (draw_ack)
      ack_count++;
  end

  function automatic int bjValue(input int rank);
    if (rank == 1) return 11;
    if (rank >= 11) return 10;
    return rank;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic clearDeckModel();
    for (int i = 0; i < 52; i++)
      seen[i] = 1'b0;
    model_left = 52;
  endtask

  task automatic writeScript(input int rank);
    @(negedge clk);
    script_wr   = 1'b1;
    script_rank = 4'(rank);
    @(posedge clk);
    #1;
    script_wr = 1'b0;
  endtask

  // Push the expectation, raise draw_req for 'width' cycles, then pop and
  // compare when the ack arrives.
  task automatic applyStimulus(input kind_t kind, input int rank, input int width);
    sb_item_t item;
    sb_item_t exp_item;
    int       cyc;
    int       lat;
    int       slot;
    bit       got;
    item.kind  = kind;
    item.rank  = rank;
    item.value = (kind == KIND_SCRIPT) ? bjValue(rank) : 0;
    sb_queue.push_back(item);
    draw_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    draw_req = 1'b1;
    got = 1'b0;
    lat = 0;
    cyc = 0;
    while (cyc < 150 && !(got && cyc >= width)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= width)
        draw_req = 1'b0;
      if (draw_ack && !got) begin
        got      = 1'b1;
        lat      = cyc;
        exp_item = sb_queue.pop_front();
        case (exp_item.kind)
          KIND_SCRIPT: begin
            checkOutput("script_latency", lat, 2);
            checkOutput("script_value", int'(card_value), exp_item.value);
            checkOutput("script_rank", int'(card_rank), exp_item.rank);
            checkOutput("script_suit", int'(card_suit), 0);
            checkOutput("script_err", int'(draw_err), 0);
            checkOutput("script_cards_left", int'(cards_left), model_left);
          end
          KIND_RANDOM: begin
            model_left--;
            checkOutput("rand_err", int'(draw_err), 0);
            checkOutput("rand_cards_left", int'(cards_left), model_left);
            checkOutput("rand_rank_range", int'(card_rank >= 4'd1 && card_rank <= 4'd13), 1);
            if (card_rank >= 4'd1 && card_rank <= 4'd13) begin
              slot = int'(card_suit) * 13 + int'(card_rank) - 1;
              checkOutput("rand_unique", int'(seen[slot]), 0);
              seen[slot] = 1'b1;
              checkOutput("rand_value", int'(card_value), bjValue(int'(card_rank)));
            end
          end
          default: begin
            checkOutput("err_flag", int'(draw_err), 1);
            checkOutput("err_value", int'(card_value), 0);
            checkOutput("err_rank_held", int'(card_rank), exp_item.rank);
            checkOutput("err_suit_held", int'(card_suit), 0);
            checkOutput("err_cards_left", int'(cards_left), 0);
          end
        endcase
      end
    end
    draw_req = 1'b0;
    if (!got) begin
      exp_item = sb_queue.pop_front();
      checkOutput("ack_timeout", 0, 1);
    end
  endtask

  initial begin
    reset       = 1'b1;
    shuffle     = 1'b0;
    draw_req    = 1'b0;
    script_wr   = 1'b0;
    script_rank = 4'd0;
    clearDeckModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_cards_left", int'(cards_left), 52);
    checkOutput("rst_deck_empty", int'(deck_empty), 0);
    checkOutput("rst_draw_ack", int'(draw_ack), 0);
    checkOutput("rst_card_value", int'(card_value), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_script_full", int'(script_full), 0);

    $display("[TB] scripted 10,8,4");
    writeScript(10);
    writeScript(8);
    writeScript(4);
    applyStimulus(KIND_SCRIPT, 10, 2);
    applyStimulus(KIND_SCRIPT, 8, 2);
    applyStimulus(KIND_SCRIPT, 4, 2);

    $display("[TB] scripted blackjack/split hands and rank sanitising");
    writeScript(1);
    writeScript(12);
    writeScript(10);
    writeScript(10);
    writeScript(0);
    writeScript(15);
    applyStimulus(KIND_SCRIPT, 1, 2);
    applyStimulus(KIND_SCRIPT, 12, 2);
    applyStimulus(KIND_SCRIPT, 10, 2);
    applyStimulus(KIND_SCRIPT, 10, 2);
    applyStimulus(KIND_SCRIPT, 10, 2);
    applyStimulus(KIND_SCRIPT, 10, 2);

    $display("[TB] held request gives one draw");
    writeScript(5);
    ack_before = ack_count;
    applyStimulus(KIND_SCRIPT, 5, 8);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("held_req_single_ack", ack_count - ack_before, 1);

    $display("[TB] full random deal");
    for (int n = 0; n < 52; n++)
      applyStimulus(KIND_RANDOM, 0, 2);
    @(negedge clk);
    checkOutput("deal_deck_empty", int'(deck_empty), 1);
    checkOutput("deal_cards_left", int'(cards_left), 0);

    writeScript(7);
    applyStimulus(KIND_SCRIPT, 7, 2);
    applyStimulus(KIND_ERROR, 7, 2);

    $display("[TB] shuffle abort");
    @(negedge clk);
    shuffle = 1'b1;
    @(posedge clk);
    #1;
    shuffle = 1'b0;
    checkOutput("shuffle_refill", int'(cards_left), 52);
    checkOutput("shuffle_not_empty", int'(deck_empty), 0);
    clearDeckModel();
    for (int n = 0; n < 50; n++)
      applyStimulus(KIND_RANDOM, 0, 2);
    ack_before = ack_count;
    @(posedge clk);
    @(negedge clk);
    draw_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("abort_busy_before", int'(busy), 1);
    @(negedge clk);
    shuffle = 1'b1;
    @(posedge clk);
    #1;
    shuffle  = 1'b0;
    draw_req = 1'b0;
    checkOutput("abort_cards_left", int'(cards_left), 52);
    checkOutput("abort_idle", int'(busy), 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_no_ack", ack_count - ack_before, 0);
    clearDeckModel();
    applyStimulus(KIND_RANDOM, 0, 2);

    $display("[TB] script FIFO overflow");
    for (int i = 0; i < 9; i++) begin
      writeScript(2 + i);
      if (i == 6) checkOutput("fifo_full_after7", int'(script_full), 0);
      if (i == 7) checkOutput("fifo_full_after8", int'(script_full), 1);
      if (i == 8) checkOutput("fifo_full_after9", int'(script_full), 1);
    end
    for (int i = 0; i < 8; i++)
      applyStimulus(KIND_SCRIPT, 2 + i, 2);
    checkOutput("fifo_drained", int'(script_full), 0);
    applyStimulus(KIND_RANDOM, 0, 2);

    $display("[TB] reset mid-draw");
    ack_before = ack_count;
    @(posedge clk);
    @(negedge clk);
    draw_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b1;
    draw_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_cards_left", int'(cards_left), 52);
    checkOutput("midrst_card_value", int'(card_value), 0);
    checkOutput("midrst_card_rank", int'(card_rank), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_no_ack", ack_count - ack_before, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
